// File: rtl/fsn_multi_ctrl.sv
// Multi-channel bounded up/down value controller: level, edge and auto-repeat
// stepping of the selected channel, with wrap or saturate at the bounds.
module fsn_multi_ctrl #(
  parameter int CHANNELS = 3,
  parameter int SELW     = 2,
  parameter int WIDTH    = 10,
  parameter int MIN      = 0,
  parameter int MAX      = 359,
  parameter int STEP     = 1,
  parameter int DELAY    = 8,
  parameter int PERIOD   = 2
) (
  input  logic                      Clock,
  input  logic                      resetn,
  input  logic                      in1,
  input  logic                      in2,
  input  logic [SELW-1:0]           sel,
  input  logic [1:0]                mode,
  input  logic                      wrap,
  input  logic                      clr,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic                      changing,
  output logic                      limit,
  output logic                      busy
);

  localparam int CNTW = $clog2((DELAY > PERIOD) ? DELAY : PERIOD) + 1;
  localparam logic [CNTW-1:0]  DELAY_LD   = CNTW'(DELAY - 1);
  localparam logic [CNTW-1:0]  PERIOD_LD  = CNTW'(PERIOD - 1);
  localparam logic [WIDTH-1:0] MIN_V      = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX);
  localparam logic [WIDTH:0]   STEP_X     = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MAX_X      = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   MINSTEP_X  = (WIDTH+1)'(MIN + STEP);

  typedef enum logic [1:0] {IDLE, LOCK, HOLD, REPEAT} state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic              lat_up;
  logic [SELW-1:0]   lat_sel;
  logic [WIDTH-1:0]  vals [CHANNELS];

  logic              req;
  logic              sel_ok;
  logic              abort;
  logic              do_step;
  logic              do_clr;
  logic [WIDTH-1:0]  cur;
  logic [WIDTH:0]    step_res;

  // Bounded step at WIDTH+1 bits; MSB of the result flags a wrap/clamp event.
  function automatic logic [WIDTH:0] step_calc(input logic [WIDTH-1:0] v,
                                               input logic up,
                                               input logic wr);
    logic [WIDTH:0] ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;
    ext = {1'b0, v};
    sum = ext + STEP_X;
    dif = ext - STEP_X;
    if (up) begin
      if (sum > MAX_X) return {1'b1, (wr ? MIN_V : MAX_V)};
      return {1'b0, sum[WIDTH-1:0]};
    end
    if (ext < MINSTEP_X) return {1'b1, (wr ? MAX_V : MIN_V)};
    return {1'b0, dif[WIDTH-1:0]};
  endfunction

  assign req    = in1 ^ in2;
  assign sel_ok = ({1'b0, sel} < (SELW+1)'(CHANNELS));
  assign abort  = (state != IDLE) && req && ((in1 != lat_up) || (sel != lat_sel));
  assign do_clr = sel_ok && clr;
  assign busy   = (state != IDLE);

  always_comb begin
    cur = MIN_V;
    for (int i = 0; i < CHANNELS; i++)
      if (SELW'(i) == sel) cur = vals[i];
  end

  assign step_res = step_calc(cur, in1, wrap);

  always_comb begin
    do_step = 1'b0;
    if (sel_ok && !clr && req) begin
      case (state)
        IDLE:        do_step = 1'b1;
        HOLD, REPEAT: do_step = !abort && (cnt == '0);
        default:     do_step = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge resetn) begin
    if (resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_up   <= 1'b0;
      lat_sel  <= '0;
      changing <= 1'b0;
      limit    <= 1'b0;
    end else begin
      changing <= do_step && !step_res[WIDTH];
      limit    <= do_step && step_res[WIDTH];
      if (!sel_ok) begin
        state <= IDLE;
      end else if (clr) begin
        state   <= req ? LOCK : IDLE;
        lat_up  <= in1;
        lat_sel <= sel;
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              lat_up  <= in1;
              lat_sel <= sel;
              case (mode)
                2'b00:   state <= IDLE;
                2'b10: begin
                  state <= HOLD;
                  cnt   <= DELAY_LD;
                end
                default: state <= LOCK;
              endcase
            end
          end
          LOCK: begin
            if (!req || abort) state <= IDLE;
          end
          HOLD, REPEAT: begin
            if (!req || abort) begin
              state <= IDLE;
            end else if (cnt == '0) begin
              state <= REPEAT;
              cnt   <= PERIOD_LD;
            end else begin
              cnt <= cnt - CNTW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Only the selected channel is ever written; clear wins over a step.
  always_ff @(posedge Clock or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < CHANNELS; i++) vals[i] <= MIN_V;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (SELW'(i) == sel) begin
          if (do_clr)       vals[i] <= MIN_V;
          else if (do_step) vals[i] <= step_res[WIDTH-1:0];
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign out[g*WIDTH +: WIDTH] = vals[g];
  end

endmodule

// File: tb/tb_fsn_multi_ctrl.sv
// Directed bench for fsn_multi_ctrl with default parameters (3 x 10-bit, 0..359).
module tb_fsn_multi_ctrl;

  logic        Clock = 1'b0;
  logic        resetn;
  logic        in1, in2, wrap, clr;
  logic [1:0]  sel;
  logic [1:0]  mode;
  logic [29:0] out;
  logic        changing, limit, busy;

  int n_chk = 0;
  int n_fail = 0;

  fsn_multi_ctrl dut (
    .Clock(Clock), .resetn(resetn), .in1(in1), .in2(in2), .sel(sel),
    .mode(mode), .wrap(wrap), .clr(clr), .out(out),
    .changing(changing), .limit(limit), .busy(busy)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] pk(input int c0, input int c1, input int c2);
    return {10'(c2), 10'(c1), 10'(c0)};
  endfunction

  task automatic chk_st(input string tag, input logic [29:0] exp_out,
                        input logic exp_chg, input logic exp_lim, input logic exp_busy);
    chk({tag, ".out"}, 32'(out), 32'(exp_out));
    chk({tag, ".changing"}, 32'(changing), 32'(exp_chg));
    chk({tag, ".limit"}, 32'(limit), 32'(exp_lim));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    resetn = 1'b1; in1 = 0; in2 = 0; wrap = 0; clr = 0; sel = 0; mode = 0;
    tick(); tick();
    chk_st("reset", pk(0, 0, 0), 0, 0, 0);
    resetn = 1'b0;
    tick();
    chk_st("post_reset", pk(0, 0, 0), 0, 0, 0);

    // Edge mode: one step per press
    mode = 2'b01; sel = 0; in1 = 1;
    tick();
    chk_st("edge_first", pk(1, 0, 0), 1, 0, 1);
    tick();
    chk_st("edge_second", pk(1, 0, 0), 0, 0, 1);
    for (int i = 0; i < 8; i++) tick();
    chk_st("edge_held", pk(1, 0, 0), 0, 0, 1);
    in1 = 0;
    tick();
    chk_st("edge_release", pk(1, 0, 0), 0, 0, 0);

    // Repeat mode: steps at edges 0, 8, 10, 12
    mode = 2'b10; sel = 1; in1 = 1;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk($sformatf("rep_ch1_%0d", i), 32'(out[19:10]),
          (i < 8) ? 32'd1 : 32'(2 + (i - 8) / 2));
      chk($sformatf("rep_busy_%0d", i), 32'(busy), 32'd1);
    end
    in1 = 0;
    tick();
    chk_st("rep_release", pk(1, 4, 0), 0, 0, 0);

    // Wrap at both bounds on ch2
    mode = 2'b01; sel = 2; wrap = 1; in2 = 1;
    tick();
    chk_st("wrap_down0", pk(1, 4, 359), 0, 1, 1);
    in2 = 0; tick();
    in1 = 1;
    tick();
    chk_st("wrap_up", pk(1, 4, 0), 0, 1, 1);
    in1 = 0; tick();
    in2 = 1;
    tick();
    chk_st("wrap_down", pk(1, 4, 359), 0, 1, 1);
    in2 = 0; tick();

    // Clear ch0, then saturate at MIN in level mode
    sel = 0; clr = 1;
    tick();
    chk_st("clr_ch0", pk(0, 4, 359), 0, 0, 0);
    clr = 0; wrap = 0; mode = 2'b00; in2 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_st($sformatf("sat_min_%0d", i), pk(0, 4, 359), 0, 1, 0);
    end
    in2 = 0;
    tick();
    chk_st("sat_release", pk(0, 4, 359), 0, 0, 0);

    // Saturate at MAX
    sel = 2; in1 = 1;
    tick();
    chk_st("sat_max", pk(0, 4, 359), 0, 1, 0);
    in1 = 0; tick();

    // Direction switch in repeat mode aborts without a step
    sel = 1; mode = 2'b10; in1 = 1;
    tick();
    chk_st("sw_up", pk(0, 5, 359), 1, 0, 1);
    tick(); tick(); tick();
    chk_st("sw_held", pk(0, 5, 359), 0, 0, 1);
    in1 = 0; in2 = 1;
    tick();
    chk_st("sw_abort", pk(0, 5, 359), 0, 0, 0);
    tick();
    chk_st("sw_down", pk(0, 4, 359), 1, 0, 1);
    in2 = 0; tick();

    // Level mode steps every cycle
    sel = 0; mode = 2'b00; in1 = 1;
    tick(); tick(); tick();
    chk_st("level_up", pk(3, 4, 359), 1, 0, 0);
    in1 = 0; tick();

    // Out-of-range select is ignored
    sel = 3; in1 = 1;
    tick();
    chk_st("sel_invalid", pk(3, 4, 359), 0, 0, 0);
    in1 = 0; tick();

    // Asynchronous reset while in REPEAT
    sel = 0; mode = 2'b10; in1 = 1;
    for (int i = 0; i < 10; i++) tick();
    chk_st("pre_reset_rep", pk(5, 4, 359), 0, 0, 1);
    #2 resetn = 1'b1;
    #1;
    chk_st("async_reset", pk(0, 0, 0), 0, 0, 0);
    @(negedge Clock);
    resetn = 1'b0;
    tick();
    chk_st("repress_after_reset", pk(1, 0, 0), 1, 0, 1);
    in1 = 0; tick();

    // clr with a request: clear wins, FSM locks until release
    sel = 1; mode = 2'b01; in1 = 1;
    tick();
    in1 = 0; tick();
    chk_st("clr_setup", pk(1, 1, 0), 0, 0, 0);
    clr = 1; in1 = 1;
    tick();
    chk_st("clr_with_in1", pk(1, 0, 0), 0, 0, 1);
    clr = 0;
    tick();
    chk_st("clr_lock", pk(1, 0, 0), 0, 0, 1);
    in1 = 0;
    tick();
    chk_st("clr_release", pk(1, 0, 0), 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fsn_multi_ctrl.md
# fsn_multi_ctrl

Multi-channel bounded up/down value controller driven by two push-button requests (increment/decrement). It holds CHANNELS independent values, each bounded to [MIN, MAX], and steps the selected one per a run-time mode: level, single-step-per-press, or press-and-hold auto-repeat with initial delay. It sits between debounced user buttons and the object-transform datapath, for example rotation angles per axis, and replaces single-value controllers.

## Interface
- CHANNELS, 3, number of independent stored values
- SELW, 2, width of channel select; CHANNELS ≤ 2^SELW
- WIDTH, 10, bits per stored value
- MIN, 0, lower bound, unsigned, ≥ 0
- MAX, 359, upper bound, unsigned, MIN ≤ MAX < 2^WIDTH
- STEP, 1, increment/decrement magnitude, 1 ≤ STEP ≤ MAX−MIN+1
- DELAY, 8, cycles from first step to second step in repeat mode, ≥ 2
- PERIOD, 2, cycles between subsequent repeat steps, ≥ 1

Ports:
- Clock  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-high reset
- in1  in  1  increment request
- in2  in  1  decrement request
- sel  in  SELW  channel select; values ≥ CHANNELS ignore requests
- mode  in  2  00 level, 01 edge, 10 repeat, 11 treated as edge
- wrap  in  1  1 = wrap at bounds, 0 = saturate
- clr  in  1  synchronous: selected channel ← MIN
- out  out  CHANNELS*WIDTH  packed values; channel i at [i*WIDTH +: WIDTH]
- changing  out  1  registered; 1 for one cycle after an in-range step
- limit  out  1  registered; 1 for one cycle after a wrap or clamp
- busy  out  1  FSM not in IDLE

## Operation
- Request `req` = in1 XOR in2. Direction is up if in1, down if in2. Both or neither means no request.
- Reset: all channels = MIN; changing = limit = 0; FSM = IDLE; counter = 0.
- Step arithmetic is done at WIDTH+1 bits. Let v be the selected value.
  - Up: if v+STEP > MAX, the result is MIN when wrap=1, else MAX. This is a limit event.
  - Down: if v < MIN+STEP (no borrow through 0), the result is MAX when wrap=1, else MIN. This is a limit event.
  - Otherwise the result is v±STEP. This is a changing event.
  - Wrap goes to the bound exactly, not modulo. A saturate step at the bound leaves v unchanged and still flags limit.
- FSM states: IDLE, LOCK, HOLD, REPEAT. Direction and sel are latched on leaving IDLE.
  - IDLE: if req, step once.
    - mode 00: stay in IDLE, so the value steps every cycle while req is held.
    - mode 01/11: go to LOCK.
    - mode 10: go to HOLD with cnt = DELAY−1.
  - LOCK: no steps. When req=0, go to IDLE.
  - HOLD: cnt decrements each cycle.
    - When cnt = 0 and req is still held: step, go to REPEAT with cnt = PERIOD−1.
    - When req=0: go to IDLE.
  - REPEAT: cnt decrements each cycle. When cnt = 0: step, reload PERIOD−1. When req=0: go to IDLE.
- Abort: in LOCK/HOLD/REPEAT, a change of direction or sel from the latched value returns the FSM to IDLE with no step that cycle. A new press is then recognised on the next cycle.
- mode and wrap are sampled at each step. A mode change takes effect only on the next IDLE exit.
- clr has priority over any step in the same cycle. It flags neither changing nor limit, and sends the FSM to LOCK if req=1, else to IDLE.
- If sel ≥ CHANNELS, no value changes and the FSM stays in IDLE.
- Non-selected channels never change.

## Timing
- A request sampled at edge k updates out at edge k. changing/limit are high during cycle k→k+1 only.
- Repeat mode, held continuously: steps at edges k, k+DELAY, k+DELAY+PERIOD, k+DELAY+2·PERIOD, …
- Edge mode: exactly one step per press. A release of at least one cycle is required before the next step.
- Reset asserted mid-hold: outputs return to reset values immediately (asynchronous). After release, a still-held request is treated as a new press.
- changing and limit are never high together.

## Test plan
- Reset, mode=01, sel=0, pulse in1 for 10 cycles → ch0 = 1 after one edge; changing high 1 cycle; no further steps; ch1/ch2 stay 0.
- mode=10, hold in1 for 14 cycles on sel=1 from 0 → steps at cycles 0, 8, 10, 12; ch1 = 4; busy high throughout, low one cycle after release.
- wrap=1, ch2 = 359, mode=01, press in1 → ch2 = 0 with limit pulse. Then press in2 → ch2 = 359 with limit pulse.
- wrap=0, ch0 = 0, mode=00, hold in2 for 3 cycles → ch0 stays 0; limit high each cycle; changing never high.
- mode=10, hold in1 4 cycles, switch to in2 without release → up step at cycle 0, no step on the switch cycle, down step the next cycle. Net value unchanged.
- Assert resetn in REPEAT, and separately assert clr together with in1 → all outputs at reset values; clr zeroes only the selected channel and suppresses the step.
